// File: rtl/dma_rom.sv
// rtl/dma_rom.sv - DMA read-side source memory with one-shot load phase and seal lock.
// Define DMA_ROM_IDENTITY_INIT_EN to preset mem[i] = i on reset instead of leaving RAM uninitialised.
module dma_rom #(
  parameter int DEPTH  = 256,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [WIDTH-1:0]  load_data,
  input  logic              seal,
  output logic              sealed,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              err
);

  localparam int              IDX_W     = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {UNSEALED = 1'b0, SEALED = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];

  logic load_in_range;
  logic rd_in_range;
  logic load_ok;
  logic load_rej;
  logic rd_rej;

  // Out-of-range addresses are rejected, never folded modulo DEPTH.
  assign load_in_range = {1'b0, load_addr} < DEPTH_LIM;
  assign rd_in_range   = {1'b0, rd_addr} < DEPTH_LIM;

  assign load_ok  = load_en && (state == UNSEALED) && load_in_range;
  assign load_rej = load_en && ((state == SEALED) || !load_in_range);
  assign rd_rej   = rd_en && !rd_in_range;

  assign sealed = (state == SEALED);

`ifdef DMA_ROM_IDENTITY_INIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= WIDTH'(i);
      end
    end else if (load_ok) begin
      mem[load_addr[IDX_W-1:0]] <= load_data;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem[load_addr[IDX_W-1:0]] <= load_data;
    end
  end
`endif

  // Read samples mem before this edge's load lands, giving read-before-write on collisions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= UNSEALED;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (seal) begin
        state <= SEALED;
      end
      rd_valid <= rd_en;
      err      <= load_rej || rd_rej;
      if (rd_en) begin
        rd_data <= rd_in_range ? mem[rd_addr[IDX_W-1:0]] : '0;
      end
    end
  end

endmodule

// File: tb/tb_dma_rom.sv
// tb/tb_dma_rom.sv - self-checking bench for dma_rom (DEPTH=200): vector table, corner sequences, random vs model.
module tb_dma_rom;

  localparam int DEPTH = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_en = 1'b0;
  logic [7:0] load_addr = '0;
  logic [7:0] load_data = '0;
  logic       seal = 1'b0;
  logic       sealed;
  logic       rd_en = 1'b0;
  logic [7:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       err;

  int tests = 0;
  int fails = 0;

  dma_rom #(.DEPTH(DEPTH), .WIDTH(8), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .seal(seal), .sealed(sealed),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rd_en;
    logic [7:0] rd_addr;
    bit         load_en;
    logic [7:0] load_addr;
    logic [7:0] load_data;
    logic [7:0] exp_data;
    bit         exp_valid;
    bit         exp_err;
  } vec_t;

  vec_t vecs [13];

  int  m_mem   [256];
  bit  m_known [256];
  bit  m_sealed;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_en = 1'b0;
    seal    = 1'b0;
    rd_en   = 1'b0;
  endtask

  initial begin
    #2;
    chk("reset rd_data", rd_data, 0);
    chk("reset rd_valid", rd_valid, 0);
    chk("reset err", err, 0);
    chk("reset sealed", sealed, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill 0..DEPTH-1 with identity data so reads have known contents in either build.
    for (int i = 0; i < DEPTH; i++) begin
      load_en = 1'b1; load_addr = 8'(i); load_data = 8'(i);
      step();
    end
    idle_inputs();
    step();
    chk("fill err", err, 0);

    vecs[0]  = '{1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 8'h20, 1'b1, 8'h20, 8'h77, 8'h20, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 8'h20, 1'b0, 8'h00, 8'h00, 8'h77, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 8'd250, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 8'h55, 1'b0, 8'h00, 8'h00, 8'h55, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h55, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 8'd210, 8'h99, 8'h55, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 8'd199, 1'b0, 8'h00, 8'h00, 8'd199, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 8'd200, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 8'h11, 1'b1, 8'h10, 8'hA5, 8'h11, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 8'h10, 1'b0, 8'h00, 8'h00, 8'hA5, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 8'hFA, 1'b1, 8'd210, 8'h01, 8'h00, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 8'd5, 1'b0, 8'h00, 8'h00, 8'd5, 1'b1, 1'b0};

    for (int v = 0; v < 13; v++) begin
      rd_en = vecs[v].rd_en; rd_addr = vecs[v].rd_addr;
      load_en = vecs[v].load_en; load_addr = vecs[v].load_addr; load_data = vecs[v].load_data;
      step();
      chk($sformatf("vec%0d rd_data", v), rd_data, vecs[v].exp_data);
      chk($sformatf("vec%0d rd_valid", v), rd_valid, vecs[v].exp_valid);
      chk($sformatf("vec%0d err", v), err, vecs[v].exp_err);
    end
    idle_inputs();

    // Seal, then a load to 0x10 must be rejected and the old word preserved.
    seal = 1'b1;
    step();
    seal = 1'b0;
    chk("seal sealed", sealed, 1);
    load_en = 1'b1; load_addr = 8'h10; load_data = 8'h3C;
    step();
    chk("sealed load err", err, 1);
    idle_inputs();
    rd_en = 1'b1; rd_addr = 8'h10;
    step();
    chk("sealed read data", rd_data, 8'hA5);
    chk("sealed read err", err, 0);
    chk("sealed stays", sealed, 1);

    // Reset arriving while a read is outstanding.
    rd_addr = 8'h11;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst rd_data", rd_data, 0);
    chk("async rst rd_valid", rd_valid, 0);
    chk("async rst sealed", sealed, 0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post rst rd_valid", rd_valid, 0);
    chk("post rst rd_data", rd_data, 0);

    // Seal and load in the same cycle: the load wins, the lock follows.
    load_en = 1'b1; load_addr = 8'd5; load_data = 8'h11; seal = 1'b1;
    step();
    chk("seal+load sealed", sealed, 1);
    chk("seal+load err", err, 0);
    seal = 1'b0; load_addr = 8'd6; load_data = 8'h22;
    step();
    chk("post seal load err", err, 1);
    idle_inputs();
    rd_en = 1'b1; rd_addr = 8'd5;
    step();
    chk("seal+load word5", rd_data, 8'h11);
    idle_inputs();

    // Random phase against a behavioural model.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_sealed = 1'b0;
    for (int i = 0; i < 256; i++) begin
      m_known[i] = 1'b0;
      m_mem[i] = 0;
    end
    begin
      int  exp_data;
      bit  data_known;
      bit  e_err;
      exp_data = 0;
      data_known = 1'b1;
      for (int c = 0; c < 1500; c++) begin
        load_en   = ($urandom_range(0, 1) == 1);
        load_addr = 8'($urandom_range(0, 255));
        load_data = 8'($urandom);
        rd_en     = ($urandom_range(0, 3) != 0);
        rd_addr   = (c % 5 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, DEPTH - 1));
        seal      = ($urandom_range(0, 999) == 0);

        e_err = (load_en && (m_sealed || load_addr >= DEPTH)) || (rd_en && rd_addr >= DEPTH);
        if (rd_en) begin
          if (rd_addr >= DEPTH) begin
            exp_data = 0; data_known = 1'b1;
          end else begin
            exp_data = m_mem[rd_addr]; data_known = m_known[rd_addr];
          end
        end
        if (load_en && !m_sealed && load_addr < DEPTH) begin
          m_mem[load_addr] = load_data;
          m_known[load_addr] = 1'b1;
        end
        if (seal) m_sealed = 1'b1;

        step();
        chk($sformatf("rand%0d err", c), err, e_err);
        chk($sformatf("rand%0d rd_valid", c), rd_valid, rd_en);
        chk($sformatf("rand%0d sealed", c), sealed, m_sealed);
        if (data_known) chk($sformatf("rand%0d rd_data", c), rd_data, exp_data);
      end
    end
    idle_inputs();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
